// File: rtl/i2s_rx_ctrl.sv
// ----------------------------------------------------------------------------
// i2s_rx_ctrl
//
// Receive-side I2S link controller. Generates the bit clock (sclk) and word
// select (lrclk) from mclk, sequences the downstream deserializer's reset so
// that it starts cleanly on bit 0 of a frame, and captures the left/right
// words once per 64-bit frame into an output register with a valid/ready
// handshake. A capture that lands on an unconsumed sample overwrites it and
// is reported as an overrun.
//
// Ports
//   mclk           : master clock, the only clock (rising edge)
//   reset          : synchronous, active-high reset
//   enable         : level request to run the link
//   sclk           : bit clock, mclk / (2*MCLK_DIV)
//   lrclk          : word select, 0 = left slot, 1 = right slot
//   rx_reset       : reset for the downstream deserializer
//   in_left/right  : words from the deserializer
//   out_left/right : captured sample
//   out_valid      : sample held and not yet consumed
//   out_ready      : consumer accepts the sample while out_valid is high
//   overrun        : one-cycle pulse when an unconsumed sample is replaced
//   overrun_count  : saturating overrun counter, cleared only by reset
//   busy           : link is anywhere but IDLE
// ----------------------------------------------------------------------------
module i2s_rx_ctrl #(
    parameter int DATA_RES = 24,
    parameter int MCLK_DIV = 4
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic                enable,
    output logic                sclk,
    output logic                lrclk,
    output logic                rx_reset,
    input  logic [DATA_RES-1:0] in_left,
    input  logic [DATA_RES-1:0] in_right,
    output logic [DATA_RES-1:0] out_left,
    output logic [DATA_RES-1:0] out_right,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic [7:0]          overrun_count,
    output logic                busy
);

    localparam int               DIV_W   = $clog2(MCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(MCLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_RUN,
        S_DRAIN
    } state_e;

    state_e              state_q,     state_d;
    logic [DIV_W-1:0]    div_q,       div_d;
    logic                sclk_q,      sclk_d;
    logic [5:0]          bit_cnt_q,   bit_cnt_d;
    logic                lrclk_q,     lrclk_d;
    logic                rx_reset_q,  rx_reset_d;
    logic                strobe_q,    strobe_d;
    logic [DATA_RES-1:0] out_left_q,  out_left_d;
    logic [DATA_RES-1:0] out_right_q, out_right_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q,   overrun_d;
    logic [7:0]          ovr_cnt_q,   ovr_cnt_d;

    logic div_tc;
    logic sclk_fall;
    logic wrap;

    // ------------------------------------------------------------------------
    // Next-state logic: clock generation, FSM and sample capture
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sclk_d      = sclk_q;
        bit_cnt_d   = bit_cnt_q;
        lrclk_d     = lrclk_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;
        ovr_cnt_d   = ovr_cnt_q;

        div_tc    = (div_q == DIV_MAX);
        sclk_fall = (state_q != S_IDLE) && div_tc && sclk_q;
        // The falling edge that takes the bit counter from 63 back to 0
        wrap      = sclk_fall && (bit_cnt_q == 6'd63);

        if (state_q == S_IDLE) begin
            div_d  = '0;
            sclk_d = 1'b0;
            if (enable) begin
                state_d   = S_SYNC;
                // Two sclk periods before bit 0 so the deserializer sees
                // rx_reset on the last rising edge ahead of the first frame.
                bit_cnt_d = 6'd62;
                lrclk_d   = 1'b1;
            end
        end else begin
            div_d = div_tc ? '0 : div_q + 1'b1;
            if (div_tc) begin
                sclk_d = ~sclk_q;
            end
            if (sclk_fall) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                lrclk_d   = bit_cnt_d[5];
            end
            unique case (state_q)
                S_SYNC:  if (wrap)    state_d = S_RUN;
                S_RUN:   if (!enable) state_d = S_DRAIN;
                S_DRAIN: if (wrap)    state_d = S_IDLE;
                default: ;
            endcase
        end

        rx_reset_d = (state_d == S_IDLE) || (state_d == S_SYNC);

        // Only frames that were actually clocked through RUN/DRAIN carry data;
        // the wrap closing SYNC is a partial frame.
        strobe_d = wrap && ((state_q == S_RUN) || (state_q == S_DRAIN));

        if (strobe_q) begin
            out_left_d  = in_left;
            out_right_d = in_right;
            out_valid_d = 1'b1;
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
                if (ovr_cnt_q != 8'hFF) begin
                    ovr_cnt_d = ovr_cnt_q + 8'd1;
                end
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            bit_cnt_q   <= 6'd0;
            lrclk_q     <= 1'b0;
            rx_reset_q  <= 1'b1;
            strobe_q    <= 1'b0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            bit_cnt_q   <= bit_cnt_d;
            lrclk_q     <= lrclk_d;
            rx_reset_q  <= rx_reset_d;
            strobe_q    <= strobe_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign sclk          = sclk_q;
    assign lrclk         = lrclk_q;
    assign rx_reset      = rx_reset_q;
    assign out_left      = out_left_q;
    assign out_right     = out_right_q;
    assign out_valid     = out_valid_q;
    assign overrun       = overrun_q;
    assign overrun_count = ovr_cnt_q;
    assign busy          = (state_q != S_IDLE);

endmodule
